// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the CPU-side initiator:
// default widths, latency counter width and the responder state encoding.
package mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

    // Fixed encodings keep the debug state output stable across tool versions.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, asynchronous read-first view,
// no reset so contents survive a responder reset.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // The read path sees the word as it was before any write on this edge.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, answers
// LATENCY cycles later and holds the response until the initiator takes it.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = 2
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_we,
    output state_e            state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; ready/valid outputs are pure functions of registered state.
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0]  rdata;
    logic               accept;

    assign accept = req_valid && (state_q == IDLE) && !rst;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk_i   (clka),
        .we_i    (accept && req_we),
        .addr_i  (req_addr),
        .wdata_i (req_wdata),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_we_d   = rsp_we_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Capture the pre-write word now; later writes cannot disturb it.
                    rsp_data_d = rdata;
                    rsp_we_d   = req_we;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_we_q   <= rsp_we_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_we    = rsp_we_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance at LATENCY=2 and one at LATENCY=1,
// checked against a word-array model of storage and the latency rules.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clka = 1'b0;
    logic          rst        [2];
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic          req_we     [2];
    logic [AW-1:0] req_addr   [2];
    logic [DW-1:0] req_wdata  [2];
    logic          rsp_valid  [2];
    logic          rsp_ready  [2];
    logic [DW-1:0] rsp_data   [2];
    logic          rsp_we     [2];
    state_e        state_dbg  [2];

    logic [DW-1:0] model_mem [2][256];
    bit            model_ok  [2][256];
    realtime       last_acc  [2];
    int            errors = 0;
    int            checks = 0;

    always #5 clka = ~clka;

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2)) u_lat2 (
        .clka(clka), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_we(rsp_we[0]), .state_o(state_dbg[0])
    );

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_lat1 (
        .clka(clka), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_we(rsp_we[1]), .state_o(state_dbg[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // One full transaction, starting and ending on a falling edge.
    task automatic txn(input int d, input bit we, input int addr, input logic [DW-1:0] wd,
                       input int gap, output int acc_gap);
        int            ea;
        logic [DW-1:0] exp_old;
        bit            known;
        int            n;
        realtime       t;
        ea      = addr % 256;
        exp_old = model_mem[d][ea];
        known   = model_ok[d][ea];
        checks++;
        if (req_ready[d] !== 1'b1)
            $display("FAIL req_ready_idle d=%0d: got %b expected 1", d, req_ready[d]);
        if (req_ready[d] !== 1'b1) errors++;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr[AW-1:0];
        req_wdata[d] = wd;
        rsp_ready[d] = 1'b1;
        @(posedge clka);
        t           = $realtime;
        acc_gap     = int'((t - last_acc[d]) / 10.0);
        last_acc[d] = t;
        if (we) begin
            model_mem[d][ea] = wd;
            model_ok[d][ea]  = 1'b1;
        end
        @(negedge clka);
        req_valid[d] = 1'b0;
        n = 1;
        while (rsp_valid[d] !== 1'b1 && n < 20) begin
            @(negedge clka);
            n++;
        end
        checks++;
        if (n != lat_of(d)) begin
            errors++;
            $display("FAIL latency d=%0d addr=%0h: got %0d cycles expected %0d", d, ea, n, lat_of(d));
        end
        checks++;
        if (rsp_we[d] !== we) begin
            errors++;
            $display("FAIL rsp_we d=%0d addr=%0h: got %b expected %b", d, ea, rsp_we[d], we);
        end
        if (known) begin
            checks++;
            if (rsp_data[d] !== exp_old) begin
                errors++;
                $display("FAIL rsp_data d=%0d addr=%0h: got %h expected %h", d, ea, rsp_data[d], exp_old);
            end
        end
        @(posedge clka);
        @(negedge clka);
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL return_idle d=%0d: got valid=%b ready=%b expected valid=0 ready=1",
                     d, rsp_valid[d], req_ready[d]);
        end
        repeat (gap) @(negedge clka);
    endtask

    task automatic test_reset();
        int g;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b1; req_we[d] = 1'b1;
            req_addr[d] = 8'h33; req_wdata[d] = 16'hAAAA; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clka);
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_data[d] !== '0 ||
                rsp_we[d] !== 1'b0 || state_dbg[d] !== IDLE) begin
                errors++;
                $display("FAIL reset_outputs d=%0d: got ready=%b valid=%b data=%h we=%b state=%0d expected 1 0 0000 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_data[d], rsp_we[d], state_dbg[d]);
            end
        end
        // A request held during reset must not reach storage.
        txn(0, 1'b1, 8'h33, 16'h1111, 0, g);
        rst[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0] = 8'h33; req_wdata[0] = 16'h2222;
        repeat (2) @(negedge clka);
        rst[0] = 1'b0; req_valid[0] = 1'b0;
        txn(0, 1'b0, 8'h33, 16'h0, 0, g);
    endtask

    task automatic test_write_read();
        int g;
        txn(0, 1'b1, 8'h05, 16'h1357, 1, g);
        txn(0, 1'b1, 8'h05, 16'hBEEF, 1, g);
        txn(0, 1'b0, 8'h05, 16'h0000, 1, g);
    endtask

    task automatic test_stall();
        int            g;
        int            n;
        logic [DW-1:0] held;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h05; req_wdata[0] = 16'h0;
        @(posedge clka);
        @(negedge clka);
        req_valid[0] = 1'b0;
        n = 1;
        while (rsp_valid[0] !== 1'b1 && n < 20) begin
            @(negedge clka);
            n++;
        end
        held = rsp_data[0];
        checks++;
        if (held !== model_mem[0][5]) begin
            errors++;
            $display("FAIL stall_data: got %h expected %h", held, model_mem[0][5]);
        end
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h05; req_wdata[0] = 16'h0BAD;
            @(posedge clka);
            @(negedge clka);
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== held || req_ready[0] !== 1'b0 ||
                state_dbg[0] !== RESP) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got valid=%b data=%h ready=%b expected 1 %h 0",
                         i, rsp_valid[0], rsp_data[0], req_ready[0], held);
            end
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clka);
        @(negedge clka);
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got valid=%b ready=%b expected 0 1", rsp_valid[0], req_ready[0]);
        end
        txn(0, 1'b0, 8'h05, 16'h0, 0, g);
    endtask

    task automatic test_reset_mid();
        int g;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h10; req_wdata[0] = 16'h1234;
        rsp_ready[0] = 1'b1;
        @(posedge clka);
        model_mem[0][16] = 16'h1234;
        model_ok[0][16]  = 1'b1;
        @(negedge clka);
        req_valid[0] = 1'b0;
        checks++;
        if (state_dbg[0] !== WAIT) begin
            errors++;
            $display("FAIL mid_state: got %0d expected %0d", state_dbg[0], WAIT);
        end
        rst[0] = 1'b1;
        @(posedge clka);
        @(negedge clka);
        rst[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || rsp_data[0] !== '0 || rsp_we[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b ready=%b data=%h we=%b expected 0 1 0000 0",
                     rsp_valid[0], req_ready[0], rsp_data[0], rsp_we[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            checks++;
            if (rsp_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL mid_abandon cycle %0d: got valid=%b expected 0", i, rsp_valid[0]);
            end
        end
        txn(0, 1'b0, 8'h10, 16'h0, 0, g);
    endtask

    task automatic test_back_to_back();
        int addrs [4] = '{8'hFF, 8'h00, 8'h80, 8'h7F};
        int g;
        for (int k = 0; k < 8; k++) begin
            txn(1, (k < 4), addrs[k % 4], DW'($urandom), 0, g);
            if (k > 0) begin
                checks++;
                if (g != 2) begin
                    errors++;
                    $display("FAIL b2b_period txn %0d: got %0d cycles expected 2", k, g);
                end
            end
        end
    endtask

    task automatic test_alias();
        int g;
        txn(0, 1'b1, 8'h00, 16'h0F0F, 0, g);
        txn(0, 1'b1, 'h100, 16'h5A5A, 0, g);
        txn(0, 1'b0, 8'h00, 16'h0, 0, g);
    endtask

    task automatic test_random();
        int g;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 30; k++) begin
                txn(d, 1'($urandom_range(0, 1)), $urandom_range(0, 15), DW'($urandom),
                    $urandom_range(0, 2), g);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
            last_acc[d] = 0;
        end
        @(negedge clka);
        test_reset();
        test_write_read();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_alias();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
